multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, max bus wait cycles before bus error; 0 disables timeout.
REQ-002 Parameter TW, default 4, width of the wait counter; the counter SHALL hold TIMEOUT_CYCLES.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 opcode  in  7  instruction opcode; valid from DECODE onward until the instruction completes.
REQ-006 branch_taken  in  1  branch comparison result from the ALU, sampled in EXEC.
REQ-007 bus_ready  in  1  bus handshake; a transfer completes in the cycle bus_ready=1 while bus_read or bus_write=1.
REQ-008 Outputs, each 1 bit: ir_write, pc_write, bus_read, bus_write, bus_addr_sel (0=PC, 1=ALU result), bus_to_reg, reg_write, alu_src_1, alu_src_2, out_sel, trap, bus_err.
REQ-009 Outputs pc_src (2 bits: 0=PC+4, 1=branch target, 2=ALU/jump target), alu_op (2 bits), state (3 bits, current FSM state).

Function
REQ-010 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs SHALL be Moore/registered-state decoded, with no combinational path from opcode to bus_read/bus_write.
REQ-011 FETCH: bus_read=1, bus_addr_sel=0; on bus_ready=1, ir_write=1 for that cycle only; next state DECODE.
REQ-012 DECODE: exactly 1 cycle; all strobes 0; next state EXEC.
REQ-013 EXEC: alu_src_1, alu_src_2, out_sel and alu_op per opcode class (LOAD/STORE/JAL/JALR/AUIPC add; OP_IMM imm-op; OP reg-op; BRANCH branch-compare; LUI out_sel=IMM).
REQ-014 EXEC transitions: LOAD/STORE->MEM; OP/OP_IMM/AUIPC/LUI/JAL/JALR->WB; BRANCH->FETCH with pc_write=1 and pc_src=1 if branch_taken, else 0.
REQ-015 MEM: bus_addr_sel=1; LOAD drives bus_read=1, STORE drives bus_write=1; on bus_ready=1, LOAD->WB, while STORE->FETCH with pc_write=1, pc_src=0.
REQ-016 WB: 1 cycle; reg_write=1; bus_to_reg=1 only for LOAD; pc_write=1; pc_src=2 for JAL/JALR, else 0; next state FETCH.
REQ-017 pc_write SHALL be asserted in exactly one cycle per retired instruction; bus_read and bus_write SHALL never be 1 together.
REQ-018 Wait counter clears on entry to FETCH/MEM and increments each cycle bus_ready=0; if it reaches TIMEOUT_CYCLES (nonzero), next state TRAP, bus_err=1, no ir_write/pc_write.
REQ-019 bus_ready=1 in the same cycle the counter reaches the limit SHALL complete the transfer normally (ready wins).
REQ-020 bus_ready SHALL be ignored in DECODE, EXEC, WB, TRAP.
REQ-021 TRAP: all strobes 0, trap=1, bus_err held; exit only via reset.
REQ-022 Instruction latency with zero-wait bus: BRANCH 3, STORE 4, ALU/jump 4, LOAD 5 cycles.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state FETCH, wait counter 0, trap=0, bus_err=0, all strobes 0 in that state's cycle except bus_read=1 thereafter, from any state including mid-transfer.
REQ-024 The first post-reset cycle SHALL be FETCH with bus_read=1, bus_addr_sel=0.

Configuration
REQ-025 Macro MC_ILLEGAL_TRAP_EN: when defined, an opcode outside the nine supported classes in DECODE SHALL go to TRAP with trap=1, bus_err=0.
REQ-026 Without MC_ILLEGAL_TRAP_EN, an unsupported opcode SHALL retire as a no-op: DECODE->EXEC->FETCH with pc_write=1, pc_src=0, no reg_write.

Structure
REQ-027 Shared defines package holds the opcode constants, CTL_ALU_* and alu_src/out_sel encodings, pc_src encodings, and FSM state encodings.
REQ-028 One sub-module, mc_bus_timer (wait counter and timeout compare, parametrised by TW/TIMEOUT_CYCLES).

Verification
REQ-029 Reset, then OP opcode 0110011 with bus_ready=1 -> states FETCH,DECODE,EXEC,WB,FETCH; reg_write=1 in WB; one pc_write, with pc_src=0.
REQ-030 LOAD 0000011 with bus_ready held low 3 cycles in MEM -> bus_read=1 for 4 MEM cycles; WB has bus_to_reg=1; no timeout.
REQ-031 BRANCH 1100011 with branch_taken=1 -> pc_write=1, pc_src=1 in EXEC cycle 3; then branch_taken=0 -> pc_src=0.
REQ-032 FETCH with bus_ready=0 for 15 cycles (TIMEOUT_CYCLES=15) -> TRAP, bus_err=1; then rst_n=0 one edge -> FETCH, flags 0.
REQ-033 Opcode 1111111: with MC_ILLEGAL_TRAP_EN -> TRAP, trap=1, bus_err=0; without the macro -> retires, reg_write never 1.
REQ-034 JAL 1101111 -> WB with reg_write=1, pc_src=2; rst_n=0 asserted in MEM of a STORE -> next state FETCH, bus_write=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU controls, mux selects, PC source and FSM states.
package multicycle_control_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

  localparam logic [ALUOP_W-1:0] CTL_ALU_ADD = 2'd0;
  localparam logic [ALUOP_W-1:0] CTL_ALU_IMM = 2'd1;
  localparam logic [ALUOP_W-1:0] CTL_ALU_REG = 2'd2;
  localparam logic [ALUOP_W-1:0] CTL_ALU_BR  = 2'd3;

  localparam logic ALU_SRC1_RS1 = 1'b0;
  localparam logic ALU_SRC1_PC  = 1'b1;
  localparam logic ALU_SRC2_RS2 = 1'b0;
  localparam logic ALU_SRC2_IMM = 1'b1;
  localparam logic OUT_SEL_ALU  = 1'b0;
  localparam logic OUT_SEL_IMM  = 1'b1;
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

  localparam logic [PCSRC_W-1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [PCSRC_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [PCSRC_W-1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [ST_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd1;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] ST_MEM    = 3'd3;
  localparam logic [ST_W-1:0] ST_WB     = 3'd4;
  localparam logic [ST_W-1:0] ST_TRAP   = 3'd5;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OP, CLS_OP_IMM, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_AUIPC, CLS_LUI, CLS_ILLEGAL
  } opc_class_e;

  function automatic opc_class_e decode_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD:   decode_class = CLS_LOAD;
      OPC_STORE:  decode_class = CLS_STORE;
      OPC_OP:     decode_class = CLS_OP;
      OPC_OP_IMM: decode_class = CLS_OP_IMM;
      OPC_BRANCH: decode_class = CLS_BRANCH;
      OPC_JAL:    decode_class = CLS_JAL;
      OPC_JALR:   decode_class = CLS_JALR;
      OPC_AUIPC:  decode_class = CLS_AUIPC;
      OPC_LUI:    decode_class = CLS_LUI;
      default:    decode_class = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/bus signal bundle; master is the controller, slave the datapath side.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               branch_taken;
  logic               bus_ready;
  logic               ir_write;
  logic               pc_write;
  logic               bus_read;
  logic               bus_write;
  logic               bus_addr_sel;
  logic               bus_to_reg;
  logic               reg_write;
  logic               alu_src_1;
  logic               alu_src_2;
  logic               out_sel;
  logic               trap;
  logic               bus_err;
  logic [PCSRC_W-1:0] pc_src;
  logic [ALUOP_W-1:0] alu_op;
  logic [ST_W-1:0]    state;

  modport master (
    input  opcode, branch_taken, bus_ready,
    output ir_write, pc_write, bus_read, bus_write, bus_addr_sel, bus_to_reg,
           reg_write, alu_src_1, alu_src_2, out_sel, trap, bus_err, pc_src, alu_op, state
  );

  modport slave (
    output opcode, branch_taken, bus_ready,
    input  ir_write, pc_write, bus_read, bus_write, bus_addr_sel, bus_to_reg,
           reg_write, alu_src_1, alu_src_2, out_sel, trap, bus_err, pc_src, alu_op, state
  );
endinterface

// File: rtl/multicycle_control_bus_timer.sv
// Bus wait counter: counts not-ready cycles of a FETCH/MEM transfer and flags the timeout cycle.
module mc_bus_timer #(
  parameter int unsigned TW             = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_active,
  input  logic bus_ready,
  output logic timeout_c
);

  localparam int unsigned LIMIT_M1 = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [TW-1:0] cnt_q, cnt_d;

  // Counter is zero outside a stalled transfer, so every FETCH/MEM entry starts from 0.
  always_comb begin
    cnt_d = '0;
    if (wait_active && !bus_ready) begin
      cnt_d = (cnt_q == {TW{1'b1}}) ? cnt_q : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The stall cycle that brings the count to the limit; a ready in that cycle completes instead.
  assign timeout_c = TMO_EN && wait_active && !bus_ready && (cnt_q == TW'(LIMIT_M1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with bus timeout.
// Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes instead of retiring them as no-ops.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TW             = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  logic [ST_W-1:0] state_q, state_d;
  opc_class_e      cls_q, cls_d;
  logic            bus_err_q, bus_err_d;
  logic            wait_active_c;
  logic            timeout_c;

  assign wait_active_c = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mc_bus_timer #(
    .TW             (TW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_active (wait_active_c),
    .bus_ready   (bus.bus_ready),
    .timeout_c   (timeout_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_ILLEGAL;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs decode from state_q/cls_q; only handshake strobes also see bus_ready/branch_taken.
  always_comb begin
    state_d          = state_q;
    cls_d            = cls_q;
    bus_err_d        = bus_err_q;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.bus_read     = 1'b0;
    bus.bus_write    = 1'b0;
    bus.bus_addr_sel = ADDR_SEL_PC;
    bus.bus_to_reg   = 1'b0;
    bus.reg_write    = 1'b0;
    bus.alu_src_1    = ALU_SRC1_RS1;
    bus.alu_src_2    = ALU_SRC2_RS2;
    bus.out_sel      = OUT_SEL_ALU;
    bus.alu_op       = CTL_ALU_ADD;
    bus.pc_src       = PC_SRC_PC4;
    bus.trap         = 1'b0;
    bus.bus_err      = bus_err_q;
    bus.state        = state_q;

    case (state_q)
      ST_FETCH: begin
        bus.bus_read = 1'b1;
        if (bus.bus_ready) begin
          bus.ir_write = 1'b1;
          state_d      = ST_DECODE;
        end else if (timeout_c) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end

      ST_DECODE: begin
        cls_d   = decode_class(bus.opcode);
        state_d = ST_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
        if (cls_d == CLS_ILLEGAL) state_d = ST_TRAP;
`endif
      end

      ST_EXEC: begin
        state_d = ST_WB;
        case (cls_q)
          CLS_LOAD, CLS_STORE: begin
            bus.alu_src_2 = ALU_SRC2_IMM;
            state_d       = ST_MEM;
          end
          CLS_JALR: bus.alu_src_2 = ALU_SRC2_IMM;
          CLS_JAL, CLS_AUIPC: begin
            bus.alu_src_1 = ALU_SRC1_PC;
            bus.alu_src_2 = ALU_SRC2_IMM;
          end
          CLS_OP_IMM: begin
            bus.alu_op    = CTL_ALU_IMM;
            bus.alu_src_2 = ALU_SRC2_IMM;
          end
          CLS_OP:  bus.alu_op  = CTL_ALU_REG;
          CLS_LUI: bus.out_sel = OUT_SEL_IMM;
          CLS_BRANCH: begin
            bus.alu_op   = CTL_ALU_BR;
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.branch_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
            state_d      = ST_FETCH;
          end
          default: begin
            // Unsupported opcode retires as a no-op
            bus.pc_write = 1'b1;
            state_d      = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        bus.bus_addr_sel = ADDR_SEL_ALU;
        bus.bus_read     = (cls_q == CLS_LOAD);
        bus.bus_write    = (cls_q == CLS_STORE);
        if (bus.bus_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            bus.pc_write = 1'b1;
            state_d      = ST_FETCH;
          end
        end else if (timeout_c) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end

      ST_WB: begin
        bus.reg_write  = 1'b1;
        bus.bus_to_reg = (cls_q == CLS_LOAD);
        bus.pc_write   = 1'b1;
        bus.pc_src     = ((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) ? PC_SRC_JUMP : PC_SRC_PC4;
        state_d        = ST_FETCH;
      end

      ST_TRAP: bus.trap = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds the expected per-cycle trace of each instruction from its class and wait counts.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int TMO = 15;
  localparam int C_LOAD = 0, C_STORE = 1, C_OP = 2, C_OPI = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_AUIPC = 7, C_LUI = 8, C_ILL = 9;

  typedef struct {
    bit         rst_n, ready, taken;
    logic [6:0] opc;
    logic [2:0] st;
    bit         ir_write, pc_write, bus_read, bus_write, addr_sel, bus_to_reg, reg_write, trap, bus_err;
    logic [1:0] pc_src;
    bit         chk_alu;
    logic [1:0] alu_op;
    bit         src1, src2, out_sel;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus_if ();
  multicycle_control #(.TIMEOUT_CYCLES(TMO), .TW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  cyc_t q[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;
  int   n_checks = 0, n_errors = 0, retired = 0, pcw_seen = 0;
  logic [6:0] opc_tab [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b1111111, 7'b0001111};

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_OP;
      7'b0010011: return C_OPI;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0010111: return C_AUIPC;
      7'b0110111: return C_LUI;
      default:    return C_ILL;
    endcase
  endfunction

  // Idle cycle: no strobes; ready/branch_taken random since they must be ignored unless stated.
  function automatic cyc_t base(input logic [2:0] st, input logic [6:0] opc);
    cyc_t r;
    r = '{default: 0};
    r.rst_n = 1'b1;
    r.ready = 1'($urandom);
    r.taken = 1'($urandom);
    r.opc   = opc;
    r.st    = st;
    return r;
  endfunction

  task automatic trap_and_reset(input bit berr);
    cyc_t r;
    for (int i = 0; i < 4; i++) begin
      r = base(ST_TRAP, 7'($urandom));
      r.trap = 1'b1;
      r.bus_err = berr;
      if (i == 3) r.rst_n = 1'b0;
      q.push_back(r);
    end
  endtask

  task automatic run_instr(input logic [6:0] opc, input bit taken, input int fw, input int mw, input bit rst_mid);
    cyc_t r;
    int   c, nf, nm;
    c  = cls_of(opc);
    nf = (fw < TMO) ? fw : TMO;
    for (int i = 0; i < nf; i++) begin
      r = base(ST_FETCH, 7'($urandom));
      r.ready = 1'b0; r.bus_read = 1'b1;
      q.push_back(r);
    end
    if (fw >= TMO) begin trap_and_reset(1'b1); return; end
    r = base(ST_FETCH, 7'($urandom));
    r.ready = 1'b1; r.bus_read = 1'b1; r.ir_write = 1'b1;
    q.push_back(r);
    q.push_back(base(ST_DECODE, opc));
`ifdef MC_ILLEGAL_TRAP_EN
    if (c == C_ILL) begin trap_and_reset(1'b0); return; end
`endif
    r = base(ST_EXEC, opc);
    r.chk_alu = 1'b1;
    case (c)
      C_LOAD, C_STORE, C_JALR: begin r.alu_op = CTL_ALU_ADD; r.src2 = 1'b1; end
      C_JAL, C_AUIPC: begin r.alu_op = CTL_ALU_ADD; r.src1 = 1'b1; r.src2 = 1'b1; end
      C_OPI: begin r.alu_op = CTL_ALU_IMM; r.src2 = 1'b1; end
      C_OP:  r.alu_op = CTL_ALU_REG;
      C_BR: begin
        r.alu_op = CTL_ALU_BR; r.taken = taken; r.pc_write = 1'b1;
        r.pc_src = taken ? 2'd1 : 2'd0;
      end
      C_LUI: r.out_sel = 1'b1;
      default: begin r.pc_write = 1'b1; r.pc_src = 2'd0; end
    endcase
    q.push_back(r);
    if (c == C_BR || c == C_ILL) begin retired++; return; end
    if (c == C_LOAD || c == C_STORE) begin
      nm = (mw < TMO) ? mw : TMO;
      for (int i = 0; i < nm; i++) begin
        r = base(ST_MEM, opc);
        r.ready = 1'b0; r.addr_sel = 1'b1;
        r.bus_read = (c == C_LOAD); r.bus_write = (c == C_STORE);
        if (rst_mid && i == 1) begin r.rst_n = 1'b0; q.push_back(r); return; end
        q.push_back(r);
      end
      if (mw >= TMO) begin trap_and_reset(1'b1); return; end
      r = base(ST_MEM, opc);
      r.ready = 1'b1; r.addr_sel = 1'b1;
      r.bus_read = (c == C_LOAD); r.bus_write = (c == C_STORE);
      if (c == C_STORE) begin r.pc_write = 1'b1; r.pc_src = 2'd0; end
      q.push_back(r);
      if (c == C_STORE) begin retired++; return; end
    end
    r = base(ST_WB, opc);
    r.reg_write = 1'b1; r.pc_write = 1'b1;
    r.bus_to_reg = (c == C_LOAD);
    r.pc_src = (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    q.push_back(r);
    retired++;
  endtask

  task automatic play();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk); #1;
      rst_n               = r.rst_n;
      bus_if.bus_ready    = r.ready;
      bus_if.branch_taken = r.taken;
      bus_if.opcode       = r.opc;
      cur       = r;
      cur_valid = 1'b1;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return TMO;
    if (r < 5)  return $urandom_range(5, 14);
    return $urandom_range(0, 2);
  endfunction

  // Single compare point for every cycle the trace covers.
  always @(negedge clk) begin
    if (cur_valid) begin
      chk("state",        bus_if.state,             cur.st);
      chk("ir_write",     3'(bus_if.ir_write),      3'(cur.ir_write));
      chk("pc_write",     3'(bus_if.pc_write),      3'(cur.pc_write));
      chk("bus_read",     3'(bus_if.bus_read),      3'(cur.bus_read));
      chk("bus_write",    3'(bus_if.bus_write),     3'(cur.bus_write));
      chk("bus_addr_sel", 3'(bus_if.bus_addr_sel),  3'(cur.addr_sel));
      chk("bus_to_reg",   3'(bus_if.bus_to_reg),    3'(cur.bus_to_reg));
      chk("reg_write",    3'(bus_if.reg_write),     3'(cur.reg_write));
      chk("trap",         3'(bus_if.trap),          3'(cur.trap));
      chk("bus_err",      3'(bus_if.bus_err),       3'(cur.bus_err));
      if (cur.pc_write) chk("pc_src", 3'(bus_if.pc_src), 3'(cur.pc_src));
      if (cur.chk_alu) begin
        chk("alu_op",    3'(bus_if.alu_op),    3'(cur.alu_op));
        chk("alu_src_1", 3'(bus_if.alu_src_1), 3'(cur.src1));
        chk("alu_src_2", 3'(bus_if.alu_src_2), 3'(cur.src2));
        chk("out_sel",   3'(bus_if.out_sel),   3'(cur.out_sel));
      end
      if (bus_if.pc_write === 1'b1) pcw_seen++;
    end
  end

  initial begin
    logic [6:0] opc;
    int fw, mw;
    bit rs;
    rst_n = 1'b0;
    bus_if.bus_ready = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.opcode = '0;
    repeat (2) @(posedge clk);

    // Directed: zero-wait latencies pin the trace builder itself
    run_instr(7'b0110011, 1'b0, 0, 0, 1'b0); chk_int("lat_op", q.size(), 4); play();
    run_instr(7'b0000011, 1'b0, 0, 3, 1'b0); chk_int("lat_load_3wait", q.size(), 8); play();
    run_instr(7'b1100011, 1'b1, 0, 0, 1'b0); chk_int("lat_branch_taken", q.size(), 3); play();
    run_instr(7'b1100011, 1'b0, 0, 0, 1'b0); chk_int("lat_branch_nt", q.size(), 3); play();
    run_instr(7'b0100011, 1'b0, 0, 0, 1'b0); chk_int("lat_store", q.size(), 4); play();
    run_instr(7'b0000011, 1'b0, 0, 0, 1'b0); chk_int("lat_load", q.size(), 5); play();
    run_instr(7'b1101111, 1'b0, 0, 0, 1'b0); chk_int("lat_jal", q.size(), 4); play();
    run_instr(7'b0110011, 1'b0, TMO, 0, 1'b0); chk_int("lat_fetch_timeout", q.size(), TMO + 4); play();
    run_instr(7'b0110111, 1'b0, 0, 0, 1'b0); play();
    run_instr(7'b0100011, 1'b0, 0, 4, 1'b1); play();
    run_instr(7'b0010011, 1'b0, 0, 0, 1'b0); play();
`ifdef MC_ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 1'b0, 0, 0, 1'b0); chk_int("lat_illegal_trap", q.size(), 6); play();
`else
    run_instr(7'b1111111, 1'b0, 0, 0, 1'b0); chk_int("lat_illegal_nop", q.size(), 3); play();
`endif
    run_instr(7'b0110011, 1'b0, TMO - 1, 0, 1'b0); play();
    run_instr(7'b0000011, 1'b0, 0, TMO - 1, 1'b0); play();
    run_instr(7'b0100011, 1'b0, 1, TMO, 1'b0); play();
    run_instr(7'b1100111, 1'b0, 2, 0, 1'b0); play();

    for (int k = 0; k < 250; k++) begin
      opc = opc_tab[$urandom_range(0, 10)];
      fw  = pick_wait();
      mw  = pick_wait();
      rs  = 1'b0;
      if ((cls_of(opc) == C_LOAD || cls_of(opc) == C_STORE) && $urandom_range(0, 19) == 0) begin
        rs = 1'b1;
        mw = $urandom_range(2, 10);
      end
      run_instr(opc, 1'($urandom), fw, mw, rs);
      play();
    end

    @(negedge clk); #1;
    cur_valid = 1'b0;
    chk_int("pc_write_per_retired", pcw_seen, retired);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
